// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-outstanding word fetches
// and buffers returned instructions, tagged with their PC, in a small FIFO for decode.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, req_pc;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          issue, push, pop;

    // rst_n gates the request so the memory sees nothing while reset is held.
    assign imem_req  = rst_n && (state == IDLE) && (count < FULL) && !redirect_valid;
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_ready;
    assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = if_valid && id_ready && !redirect_valid;

    assign if_valid    = (count != '0);
    assign if_instr    = if_valid ? instr_mem[rd_ptr] : '0;
    assign if_pc       = if_valid ? pc_mem[rd_ptr] : '0;
    assign if_pc_plus4 = if_valid ? pc_mem[rd_ptr] + 32'd4 : '0;

    // NOTE: state_next gets its default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = WAIT;
            WAIT: begin
                if (redirect_valid) state_next = imem_rvalid ? IDLE : DRAIN;
                else if (imem_rvalid) state_next = IDLE;
            end
            DRAIN:   if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    // NOTE: FIFO storage has no reset; count qualifies every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed corner cases, a redirect
// vector table and a randomized run checked by an in-order PC stream model.
module tb_fetch_prefetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk, rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, id_ready;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    int checks   = 0;
    int failures = 0;

    fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Memory model: one request at a time, data = addr ^ KEY, mem_lat cycles after acceptance.
    int          mem_lat    = 1;
    int          ready_mode = 1;   // 0 never ready, 1 always ready, 2 random
    logic        mem_pend   = 1'b0;
    int          mem_cnt    = 0;
    logic [31:0] mem_addr   = '0;
    logic [31:0] last_acc_addr = '0;
    logic        acc;
    logic [31:0] acc_addr;

    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always begin
        @(negedge clk);
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        if (acc) last_acc_addr = acc_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = acc_addr;
        end
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ KEY;
                mem_pend    = 1'b0;
            end
        end
        imem_ready = (ready_mode == 1) ? 1'b1 :
                     (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Reference model: between redirects decode must see consecutive word addresses from the target.
    logic [31:0] exp_pc = RESET_PC;
    int          pops   = 0;

    always @(negedge rst_n) exp_pc = RESET_PC;

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) check("sb_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (redirect_valid) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (if_valid && id_ready) begin
                check("sb_pc", if_pc, exp_pc);
                check("sb_instr", if_instr, exp_pc ^ KEY);
                check("sb_plus4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
    end

    task automatic redirect_to(input logic [31:0] pc);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    // Waits (bounded) for the next head entry with id_ready high and checks it.
    task automatic pop_expect(input logic [31:0] pc, input string tag,
                              output int waited, output logic [31:0] plus4);
        int n = 0;
        plus4 = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid && n < 60);
        waited = n;
        if (!if_valid) begin
            fail({tag, "_wait"});
        end else begin
            plus4 = if_pc_plus4;
            check({tag, "_pc"}, if_pc, pc);
            check({tag, "_instr"}, if_instr, pc ^ KEY);
        end
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_ready) && n < 60);
        if (!(imem_req && imem_ready)) fail(tag);
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] pc0, pc1, pc2;
        logic [31:0] plus4_1;
    } redir_vec_t;

    redir_vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          waited, first, n, pops_before;
        logic [31:0] p4;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_0108};
        vecs[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_0008};
        vecs[3] = '{32'h8000_0005, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_000C};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;

        // Reset values, then stream with the first if_valid in cycle 3 (release cycle = 1).
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_instr", if_instr, 0);
        check("rst_pc", if_pc, 0);
        check("rst_plus4", if_pc_plus4, 0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        id_ready = 1'b1;
        first    = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (if_valid && first == 0) first = cyc;
        end
        check("first_valid_cycle", first, 3);
        repeat (20) @(posedge clk);

        // Backpressure: four entries fill the FIFO, then drain back-to-back in order.
        #1 id_ready = 1'b0;
        redirect_to(32'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_req_low", imem_req, 0);
        check("bp_last_fetch", last_acc_addr, 32'h0000_000C);
        check("bp_head_pc", if_pc, 32'h0);
        @(posedge clk); #1 id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pop_expect(32'(4 * k), "bp", waited, p4);
            if (k < 4) check("bp_back_to_back", waited, 1);
        end

        // Redirect while a 3-cycle fetch is in flight: stale data dropped.
        mem_lat = 3;
        wait_accept("rd_accept");
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_flush", if_valid, 0);
        check("rd_drain_noreq", imem_req, 0);
        pop_expect(32'h0000_0100, "rd_first", waited, p4);

        // Redirect coincident with rvalid and pop.
        mem_lat = 1;
        #1 id_ready = 1'b0;
        redirect_to(32'h0000_0200);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_ready && if_valid) && n < 60);
        if (!(imem_req && imem_ready && if_valid)) fail("co_setup");
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        id_ready       = 1'b1;
        @(negedge clk);
        check("co_rvalid", imem_rvalid, 1);
        check("co_valid", if_valid, 1);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        @(negedge clk);
        check("co_empty", if_valid, 0);
        check("co_req", imem_req, 1);
        check("co_addr", imem_addr, 32'h0000_0300);

        // Redirect vector table, including the 2^32 wrap.
        mem_lat = 2;
        #1 id_ready = 1'b1;
        foreach (vecs[i]) begin
            redirect_to(vecs[i].target);
            pop_expect(vecs[i].pc0, "tbl0", waited, p4);
            pop_expect(vecs[i].pc1, "tbl1", waited, p4);
            check("tbl_plus4", p4, vecs[i].plus4_1);
            pop_expect(vecs[i].pc2, "tbl2", waited, p4);
        end

        // Randomized traffic against the stream model.
        ready_mode  = 2;
        pops_before = pops;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            id_ready       = ($urandom_range(0, 3) != 0);
            mem_lat        = int'($urandom_range(1, 3));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        ready_mode     = 1;
        check("rand_progress", 32'(pops - pops_before > 100), 1);

        // Async reset pulse while a fetch is outstanding; the late response is ignored.
        mem_lat = 3;
        wait_accept("ar_accept");
        ready_mode = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_req", imem_req, 0);
        check("ar_valid", if_valid, 0);
        check("ar_addr", imem_addr, RESET_PC);
        check("ar_pc", if_pc, 0);
        #1 rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_rvalid && n < 10);
        if (!imem_rvalid) fail("ar_stale_rvalid");
        @(negedge clk);
        check("ar_stale_dropped", if_valid, 0);
        ready_mode = 1;
        pop_expect(RESET_PC, "ar_first", waited, p4);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
